sc_reg_nivel_ctrl: RTL
======================

# sc_reg_nivel_ctrl

Parametrised level register/controller for the game datapath: holds the current level, steps it up or down on edge-detected active-low requests, supports synchronous clear and parallel load, and reports changes and boundary status. Generalises the fixed 2-bit level register with configurable width, upper bound, wrap/saturate mode, a change pulse and an optional step cooldown. Sits between the control FSM, which issues requests, and the display/speed logic, which consumes the level.

## Interface
- NIVEL_DATAWIDTH, 3: level width W (≥1).
- NIVEL_MAX, 5: highest legal level (≤ 2^W−1).
- NIVEL_INIT, 0: value on reset and clear (≤ NIVEL_MAX).
- NIVEL_WRAP, 0: 0 = saturate at bounds, 1 = wrap around.
- COOLDOWN_CYCLES, 4: step lockout length (≥1; used only with the macro).

- SC_RegNIVEL_CLOCK_50  in  1  system clock, rising edge.
- SC_RegNIVEL_RESET_InHigh  in  1  asynchronous, active-high reset.
- SC_RegNIVEL_clear_InLow  in  1  synchronous clear to NIVEL_INIT.
- SC_RegNIVEL_load_InLow  in  1  synchronous parallel load.
- SC_RegNIVEL_data_InBUS  in  W  load value.
- SC_RegNIVEL_up_InLow  in  1  level-up request, falling-edge triggered.
- SC_RegNIVEL_down_InLow  in  1  level-down request, falling-edge triggered.
- SC_RegNIVEL_data_OutBUS  out  W  current level, registered.
- SC_RegNIVEL_changed_OutHigh  out  1  one-cycle pulse when the level changes.
- SC_RegNIVEL_max_OutHigh  out  1  level == NIVEL_MAX, combinational from the register.
- SC_RegNIVEL_min_OutHigh  out  1  level == 0, combinational from the register.
- SC_RegNIVEL_busy_OutHigh  out  1  cooldown active.

## Operation
- All inputs are synchronous to the clock. Synchronisation is done outside the block.
- Edge detect: registers up_prev and down_prev hold the previous sample; both reset to 1. A step event occurs when prev=1 and current=0. A held-low input produces exactly one event.
- Priority per cycle: clear > load > step.
- Load: value > NIVEL_MAX is clamped to NIVEL_MAX.
- Up event and down event in the same cycle cancel: no change, no pulse, no cooldown start.
- Saturate mode (NIVEL_WRAP=0): up at NIVEL_MAX and down at 0 are no-ops. They produce no pulse and start no cooldown.
- Wrap mode (NIVEL_WRAP=1): up at NIVEL_MAX gives 0; down at 0 gives NIVEL_MAX.
- Arithmetic: W-bit. Intermediate ±1 values never exceed the bounds above.
- changed_OutHigh: registered. High for one cycle whenever the next level differs from the current one, from any source. Clear or load to an identical value gives no pulse.
- Edge-detect registers update every cycle regardless of priority. An edge that arrives during clear or load is consumed and lost.

## Timing
- Reset values: data_OutBUS = NIVEL_INIT, changed = 0, busy = 0, up_prev = down_prev = 1, cooldown counter = 0. max and min follow from NIVEL_INIT.
- Latency: a request low at rising edge k (high at edge k−1) updates data_OutBUS at edge k. changed_OutHigh is high in the cycle after edge k, aligned with the new value.
- Clear and load take effect at the sampling edge, with the same alignment for changed.
- Reset asserted mid-cooldown or mid-pulse aborts immediately to reset values.

## Configuration
- Macro: SC_REG_NIVEL_COOLDOWN_EN.
- Defined: an accepted step loads a counter with COOLDOWN_CYCLES, and busy_OutHigh is high while the counter ≠ 0.
  - Counter decrements each cycle.
  - Step events while busy are dropped, not queued. Edge detection still advances.
  - Clear zeroes the counter. Load does not touch it.
  - After a step at edge k, the next step is accepted at edge k+COOLDOWN_CYCLES at the earliest.
- Undefined: no counter is built. A step is accepted on every event, and busy_OutHigh is tied to 0.

## Test plan
- Reset then idle (W=3, MAX=5, INIT=0) → data=0, min=1, max=0, changed=0, busy=0.
- Saturate mode, six single-cycle up pulses spaced 8 cycles → levels 1,2,3,4,5,5; changed pulses five times; max=1 after the fifth pulse.
- Wrap mode at level 5: up pulse → 0. Then down pulse → 5. Each produces one changed pulse.
- Load 7 with load=0 and up edge in the same cycle → data=5 (clamped; load wins); up edge lost.
- Up and down falling together at level 2 → level stays 2, no pulse. Up held low 20 cycles → exactly one increment.
- With SC_REG_NIVEL_COOLDOWN_EN, COOLDOWN_CYCLES=4: up edges at edges 10 and 12 → only the first accepted, busy high edges 10–13. Up edge at 14 → accepted. Clear at 15 → data=0, busy=0.

Source files
------------

// File: rtl/sc_reg_nivel_ctrl.sv
// Level register/controller: edge-triggered up/down stepping, clear, clamped load, change pulse.
// Optional step cooldown enabled by defining SC_REG_NIVEL_COOLDOWN_EN.
module sc_reg_nivel_ctrl #(
   parameter int NIVEL_DATAWIDTH = 3,
   parameter int NIVEL_MAX       = 5,
   parameter int NIVEL_INIT      = 0,
   parameter int NIVEL_WRAP      = 0,
   parameter int COOLDOWN_CYCLES = 4
) (
   input  logic                       SC_RegNIVEL_CLOCK_50,
   input  logic                       SC_RegNIVEL_RESET_InHigh,
   input  logic                       SC_RegNIVEL_clear_InLow,
   input  logic                       SC_RegNIVEL_load_InLow,
   input  logic [NIVEL_DATAWIDTH-1:0] SC_RegNIVEL_data_InBUS,
   input  logic                       SC_RegNIVEL_up_InLow,
   input  logic                       SC_RegNIVEL_down_InLow,
   output logic [NIVEL_DATAWIDTH-1:0] SC_RegNIVEL_data_OutBUS,
   output logic                       SC_RegNIVEL_changed_OutHigh,
   output logic                       SC_RegNIVEL_max_OutHigh,
   output logic                       SC_RegNIVEL_min_OutHigh,
   output logic                       SC_RegNIVEL_busy_OutHigh
);

   localparam int W = NIVEL_DATAWIDTH;
   localparam logic [W-1:0] MAX_V  = W'(NIVEL_MAX);
   localparam logic [W-1:0] INIT_V = W'(NIVEL_INIT);
   localparam logic [W-1:0] ZERO_V = '0;
   localparam logic [W-1:0] ONE_V  = W'(1);

   logic [W-1:0] levelReg, levelNext, levelStep;
   logic         changedReg;
   logic         upPrevReg, downPrevReg;
   logic         upEvent, downEvent, stepAllowed, stepTaken;

`ifdef SC_REG_NIVEL_COOLDOWN_EN
   localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
   localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_CYCLES);
   logic [CW-1:0] cntReg, cntNext;

   // A count of 1 expires at this very edge, so a new step may already be taken.
   assign stepAllowed = (cntReg <= CW'(1));

   always_comb begin
      cntNext = cntReg;
      if (!SC_RegNIVEL_clear_InLow)
         cntNext = '0;
      else if (stepTaken)
         cntNext = CD_LOAD;
      else if (cntReg != '0)
         cntNext = cntReg - CW'(1);
   end

   always_ff @(posedge SC_RegNIVEL_CLOCK_50 or posedge SC_RegNIVEL_RESET_InHigh) begin
      if (SC_RegNIVEL_RESET_InHigh)
         cntReg <= '0;
      else
         cntReg <= cntNext;
   end

   assign SC_RegNIVEL_busy_OutHigh = (cntReg != '0);
`else
   assign stepAllowed = 1'b1;
   // Constant-false expression keeps the cooldown parameter referenced in this build.
   assign SC_RegNIVEL_busy_OutHigh = (COOLDOWN_CYCLES < 0);
`endif

   assign upEvent   = upPrevReg   & ~SC_RegNIVEL_up_InLow;
   assign downEvent = downPrevReg & ~SC_RegNIVEL_down_InLow;

   always_comb begin
      levelStep = levelReg;
      if (stepAllowed && upEvent && !downEvent) begin
         if (levelReg == MAX_V)
            levelStep = (NIVEL_WRAP != 0) ? ZERO_V : levelReg;
         else
            levelStep = levelReg + ONE_V;
      end else if (stepAllowed && downEvent && !upEvent) begin
         if (levelReg == ZERO_V)
            levelStep = (NIVEL_WRAP != 0) ? MAX_V : levelReg;
         else
            levelStep = levelReg - ONE_V;
      end
   end

   always_comb begin
      levelNext = levelStep;
      if (!SC_RegNIVEL_clear_InLow)
         levelNext = INIT_V;
      else if (!SC_RegNIVEL_load_InLow)
         levelNext = (SC_RegNIVEL_data_InBUS > MAX_V) ? MAX_V : SC_RegNIVEL_data_InBUS;
   end

   // Only a step that actually moves the level counts (saturated no-ops do not).
   assign stepTaken = SC_RegNIVEL_clear_InLow & SC_RegNIVEL_load_InLow & (levelStep != levelReg);

   always_ff @(posedge SC_RegNIVEL_CLOCK_50 or posedge SC_RegNIVEL_RESET_InHigh) begin
      if (SC_RegNIVEL_RESET_InHigh) begin
         levelReg    <= INIT_V;
         changedReg  <= 1'b0;
         upPrevReg   <= 1'b1;
         downPrevReg <= 1'b1;
      end else begin
         levelReg    <= levelNext;
         changedReg  <= (levelNext != levelReg);
         upPrevReg   <= SC_RegNIVEL_up_InLow;
         downPrevReg <= SC_RegNIVEL_down_InLow;
      end
   end

   assign SC_RegNIVEL_data_OutBUS     = levelReg;
   assign SC_RegNIVEL_changed_OutHigh = changedReg;
   assign SC_RegNIVEL_max_OutHigh     = (levelReg == MAX_V);
   assign SC_RegNIVEL_min_OutHigh     = (levelReg == ZERO_V);

endmodule
